// File: rtl/kalman_state_estimator_if.sv
// Estimator port bundle: step control, model matrices, measurement and results.
interface kalman_state_estimator_if #(
  parameter int WIDTH = 16,
  parameter int nos   = 4,
  parameter int noo   = 2
);
  logic                                start;
  logic                                load_x0;
  logic [nos-1:0][WIDTH-1:0]           x0;
  logic [nos-1:0][nos-1:0][WIDTH-1:0]  A;
  logic [noo-1:0][nos-1:0][WIDTH-1:0]  C;
  logic [nos-1:0][noo-1:0][WIDTH-1:0]  K;
  logic [noo-1:0][WIDTH-1:0]           y;
  logic [nos-1:0][WIDTH-1:0]           x_hat;
  logic [nos-1:0][WIDTH-1:0]           x_pred;
  logic [noo-1:0][WIDTH-1:0]           innov;
  logic                                busy;
  logic                                done;

  modport master (
    output start, load_x0, x0, A, C, K, y,
    input  x_hat, x_pred, innov, busy, done
  );

  modport slave (
    input  start, load_x0, x0, A, C, K, y,
    output x_hat, x_pred, innov, busy, done
  );
endinterface

// File: rtl/kalman_state_estimator.sv
// One Kalman estimator step (predict, innovate, correct) on a single serial MAC.
// ESTIMATOR_SATURATE_EN: saturate every reduction to WIDTH instead of wrapping.
module kalman_state_estimator #(
  parameter int WIDTH     = 16,
  parameter int nos       = 4,
  parameter int noo       = 2,
  parameter int FRAC_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  kalman_state_estimator_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + $clog2(nos);
  localparam int MD = (nos > noo) ? nos : noo;
  localparam int CW = (MD > 1) ? $clog2(MD) : 1;

  typedef enum logic [2:0] {IDLE, PRED, INNOV, CORR, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] i_q, k_q, i_last, k_last;
  logic signed [AW-1:0] acc_q, sum, shv;
  logic [nos-1:0][WIDTH-1:0] xh_q, xp_q;
  logic [noo-1:0][WIDTH-1:0] in_q, yl_q;
  logic done_q, k_end, row_end;
  logic signed [WIDTH-1:0] op_a, op_b, yi, pi, rowv, inn_v, cor_v;
  logic signed [PW-1:0] prod;
  logic signed [WIDTH:0] d_in, d_cr;

`ifdef ESTIMATOR_SATURATE_EN
  localparam logic signed [AW-1:0] SMAX =
    {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
`endif

  function automatic logic [WIDTH-1:0] red(
    input logic signed [AW-1:0] v
  );
`ifdef ESTIMATOR_SATURATE_EN
    if (v > SMAX) red = SMAX[WIDTH-1:0];
    else if (v < SMIN) red = SMIN[WIDTH-1:0];
    else red = v[WIDTH-1:0];
`else
    red = v[WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [AW-1:0] sx1(
    input logic signed [WIDTH:0] v
  );
    sx1 = $signed({{(AW-WIDTH-1){v[WIDTH]}}, v});
  endfunction

  always_comb begin
    op_a = '0;
    op_b = '0;
    yi   = '0;
    pi   = '0;
    unique case (state_q)
      PRED:
        for (int r = 0; r < nos; r++)
          for (int c = 0; c < nos; c++)
            if (i_q == CW'(r) && k_q == CW'(c)) begin
              op_a = bus.A[r][c];
              op_b = xh_q[c];
            end
      INNOV:
        for (int r = 0; r < noo; r++)
          for (int c = 0; c < nos; c++)
            if (i_q == CW'(r) && k_q == CW'(c)) begin
              op_a = bus.C[r][c];
              op_b = xp_q[c];
            end
      CORR:
        for (int r = 0; r < nos; r++)
          for (int c = 0; c < noo; c++)
            if (i_q == CW'(r) && k_q == CW'(c)) begin
              op_a = bus.K[r][c];
              op_b = in_q[c];
            end
      default: ;
    endcase
    for (int r = 0; r < noo; r++)
      if (i_q == CW'(r)) yi = yl_q[r];
    for (int r = 0; r < nos; r++)
      if (i_q == CW'(r)) pi = xp_q[r];
  end

  assign prod = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a})
              * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
  assign sum  = (k_q == '0 ? '0 : acc_q)
              + $signed({{(AW-PW){prod[PW-1]}}, prod});
  assign shv  = sum >>> FRAC_BITS;
  assign rowv = red(shv);
  assign d_in = $signed({yi[WIDTH-1], yi})
              - $signed({rowv[WIDTH-1], rowv});
  assign d_cr = $signed({pi[WIDTH-1], pi})
              + $signed({rowv[WIDTH-1], rowv});
  assign inn_v = red(sx1(d_in));
  assign cor_v = red(sx1(d_cr));

  assign k_last  = (state_q == CORR) ? CW'(noo - 1) : CW'(nos - 1);
  assign i_last  = (state_q == INNOV) ? CW'(noo - 1) : CW'(nos - 1);
  assign k_end   = (k_q == k_last);
  assign row_end = k_end && (i_q == i_last);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.load_x0 && bus.start) state_d = PRED;
      PRED:  if (row_end) state_d = INNOV;
      INNOV: if (row_end) state_d = CORR;
      CORR:  if (row_end) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      xh_q   <= '0;
      xp_q   <= '0;
      in_q   <= '0;
      yl_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == IDLE) begin
        if (bus.load_x0) begin
          xh_q <= bus.x0;
        end else if (bus.start) begin
          yl_q <= bus.y;
          i_q  <= '0;
          k_q  <= '0;
        end
      end else if (state_q != DONE) begin
        acc_q <= sum;
        if (k_end) begin
          k_q <= '0;
          i_q <= row_end ? '0 : i_q + 1'b1;
          for (int r = 0; r < nos; r++)
            if (i_q == CW'(r)) begin
              if (state_q == PRED) xp_q[r] <= rowv;
              if (state_q == CORR) xh_q[r] <= cor_v;
            end
          for (int r = 0; r < noo; r++)
            if (i_q == CW'(r) && state_q == INNOV)
              in_q[r] <= inn_v;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  assign bus.x_hat  = xh_q;
  assign bus.x_pred = xp_q;
  assign bus.innov  = in_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == PRED) || (state_q == INNOV)
                   || (state_q == CORR);
endmodule
